// File: rtl/owr_pkg.sv
// Shared constants and types for the one-wire temperature sequencer:
// owm slot codes, status bit positions, sensor commands, error codes, states.
package owr_pkg;

   localparam logic [7:0] OWM_RST = 8'h0A;
   localparam logic [7:0] OWM_WR0 = 8'h08;
   localparam logic [7:0] OWM_WR1 = 8'h09;   // also used as the read slot

   localparam int OWM_CYC = 3;
   localparam int OWM_DAT = 0;

   localparam logic [7:0] CMD_SKIP_ROM  = 8'hCC;
   localparam logic [7:0] CMD_CONVERT_T = 8'h44;
   localparam logic [7:0] CMD_READ_SP   = 8'hBE;

   localparam logic [1:0] ERR_OK      = 2'd0;
   localparam logic [1:0] ERR_NOPRES  = 2'd1;
   localparam logic [1:0] ERR_TIMEOUT = 2'd2;
   localparam logic [1:0] ERR_CRC     = 2'd3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RST1,
      ST_SKIP1,
      ST_CONV,
      ST_POLL,
      ST_RST2,
      ST_SKIP2,
      ST_READ,
      ST_RDB,
      ST_CHECK,
      ST_FIN
   } state_t;

   typedef enum logic {
      PH_ISSUE,
      PH_WAIT
   } slot_ph_t;

   function automatic logic [7:0] wr_code(input logic b);
      return b ? OWM_WR1 : OWM_WR0;
   endfunction

endpackage

// File: rtl/owr_crc8.sv
// Bit-serial Dallas/Maxim CRC-8 (x^8+x^5+x^4+1, reflected, init 0x00).
module owr_crc8 (
   input  logic       clk,
   input  logic       rst,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [7:0] crc
);

   localparam logic [7:0] POLY_REFL = 8'h8C;

   logic [7:0] r_crc;
   logic [7:0] w_shift;
   logic [7:0] w_crc_next;
   logic       w_fb;

   assign w_fb    = r_crc[0] ^ bit_in;
   assign w_shift = {1'b0, r_crc[7:1]};

   generate
      for (genvar gi = 0; gi < 8; gi++) begin : g_tap
         assign w_crc_next[gi] = w_shift[gi] ^ (POLY_REFL[gi] & w_fb);
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_crc <= 8'h00;
      end else if (en) begin
         r_crc <= w_crc_next;
      end
   end

   assign crc = r_crc;

endmodule

// File: rtl/owr_temp_seq.sv
// DS18B20 temperature read sequencer driving a sockit_owm master over its
// CPU bus: reset/presence, Convert T, poll, Read Scratchpad, CRC check.
module owr_temp_seq
   import owr_pkg::*;
#(
   parameter int BWD      = 32,
   parameter int POLL_MAX = 16383,
   parameter int GUARD    = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   output logic           busy,
   output logic           done,
   output logic [15:0]    temp,
   output logic           temp_valid,
   output logic [1:0]     err,
   output logic           bus_ren,
   output logic           bus_wen,
   output logic           bus_adr,
   output logic [BWD-1:0] bus_wdt,
   input  logic [BWD-1:0] bus_rdt
);

   localparam int PW = (POLL_MAX < 1) ? 1 : $clog2(POLL_MAX + 1);
   localparam int GW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);
   localparam logic [PW-1:0] POLL_LIM  = PW'(POLL_MAX);
   localparam logic [GW-1:0] GUARD_LIM = GW'(GUARD);

   state_t        r_state,      w_state_next;
   slot_ph_t      r_ph,         w_ph_next;
   logic [GW-1:0] r_guard,      w_guard_next;
   logic [2:0]    r_bit_cnt,    w_bit_cnt_next;
   logic [3:0]    r_byte_cnt,   w_byte_cnt_next;
   logic [PW-1:0] r_poll_cnt,   w_poll_cnt_next;
   logic [7:0]    r_shift,      w_shift_next;
   logic [7:0]    r_b0,         w_b0_next;
   logic [7:0]    r_b1,         w_b1_next;
   logic [15:0]   r_temp,       w_temp_next;
   logic          r_temp_valid, w_temp_valid_next;
   logic [1:0]    r_err,        w_err_next;

   logic       w_in_slot;
   logic       w_slot_done;
   logic       w_res;
   logic [7:0] w_cmd;
   logic [7:0] w_code;
   logic [7:0] w_byte_in;
   logic       w_crc_clr;
   logic       w_crc_en;
   logic [7:0] w_crc;
   logic       w_unused_rdt;

   assign w_unused_rdt = ^{bus_rdt[BWD-1:OWM_CYC+1], bus_rdt[OWM_CYC-1:OWM_DAT+1]};

   owr_crc8 u_crc (
      .clk    (clk),
      .rst    (rst),
      .clr    (w_crc_clr),
      .en     (w_crc_en),
      .bit_in (w_res),
      .crc    (w_crc)
   );

   assign w_in_slot   = (r_state != ST_IDLE) && (r_state != ST_CHECK) && (r_state != ST_FIN);
   assign w_res       = bus_rdt[OWM_DAT];
   // The owm busy flag lags our write, so it is only trusted after the guard.
   assign w_slot_done = w_in_slot && (r_ph == PH_WAIT) && (r_guard == GUARD_LIM)
                        && !bus_rdt[OWM_CYC];
   assign w_byte_in   = {w_res, r_shift[7:1]};

   always_comb begin
      w_cmd = 8'h00;
      case (r_state)
         ST_SKIP1, ST_SKIP2: w_cmd = CMD_SKIP_ROM;
         ST_CONV:            w_cmd = CMD_CONVERT_T;
         ST_READ:            w_cmd = CMD_READ_SP;
         default:            w_cmd = 8'h00;
      endcase
   end

   always_comb begin
      w_code = OWM_WR1;
      case (r_state)
         ST_RST1, ST_RST2:                     w_code = OWM_RST;
         ST_SKIP1, ST_CONV, ST_SKIP2, ST_READ: w_code = wr_code(w_cmd[r_bit_cnt]);
         default:                              w_code = OWM_WR1;
      endcase
   end

   assign bus_wen    = w_in_slot && (r_ph == PH_ISSUE);
   assign bus_ren    = w_in_slot && (r_ph == PH_WAIT);
   assign bus_adr    = 1'b0;
   assign bus_wdt    = bus_wen ? BWD'(w_code) : '0;
   assign busy       = (r_state != ST_IDLE) && (r_state != ST_FIN);
   assign done       = (r_state == ST_FIN);
   assign temp       = r_temp;
   assign temp_valid = r_temp_valid;
   assign err        = r_err;

   always_comb begin
      w_state_next      = r_state;
      w_ph_next         = r_ph;
      w_guard_next      = r_guard;
      w_bit_cnt_next    = r_bit_cnt;
      w_byte_cnt_next   = r_byte_cnt;
      w_poll_cnt_next   = r_poll_cnt;
      w_shift_next      = r_shift;
      w_b0_next         = r_b0;
      w_b1_next         = r_b1;
      w_temp_next       = r_temp;
      w_temp_valid_next = r_temp_valid;
      w_err_next        = r_err;
      w_crc_clr         = 1'b0;
      w_crc_en          = 1'b0;

      if (w_in_slot) begin
         if (r_ph == PH_ISSUE) begin
            w_ph_next    = PH_WAIT;
            w_guard_next = '0;
         end else if (r_guard != GUARD_LIM) begin
            w_guard_next = r_guard + GW'(1);
         end
         if (w_slot_done) begin
            w_ph_next = PH_ISSUE;
         end
      end

      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next   = ST_RST1;
               w_err_next     = ERR_OK;
               w_ph_next      = PH_ISSUE;
               w_bit_cnt_next = 3'd0;
               w_crc_clr      = 1'b1;
            end
         end
         ST_RST1, ST_RST2: begin
            if (w_slot_done) begin
               if (w_res) begin
                  w_err_next   = ERR_NOPRES;
                  w_state_next = ST_FIN;
               end else begin
                  w_state_next = (r_state == ST_RST1) ? ST_SKIP1 : ST_SKIP2;
               end
            end
         end
         ST_SKIP1, ST_CONV, ST_SKIP2, ST_READ: begin
            if (w_slot_done) begin
               if (r_bit_cnt == 3'd7) begin
                  w_bit_cnt_next = 3'd0;
                  case (r_state)
                     ST_SKIP1: w_state_next = ST_CONV;
                     ST_CONV: begin
                        w_state_next    = ST_POLL;
                        w_poll_cnt_next = '0;
                     end
                     ST_SKIP2: w_state_next = ST_READ;
                     default: begin
                        w_state_next    = ST_RDB;
                        w_byte_cnt_next = 4'd0;
                     end
                  endcase
               end else begin
                  w_bit_cnt_next = r_bit_cnt + 3'd1;
               end
            end
         end
         ST_POLL: begin
            if (w_slot_done) begin
               if (w_res) begin
                  w_state_next = ST_RST2;
               end else if (r_poll_cnt == POLL_LIM) begin
                  w_err_next   = ERR_TIMEOUT;
                  w_state_next = ST_FIN;
               end else begin
                  w_poll_cnt_next = r_poll_cnt + PW'(1);
               end
            end
         end
         ST_RDB: begin
            if (w_slot_done) begin
               w_crc_en     = 1'b1;
               w_shift_next = w_byte_in;
               if (r_bit_cnt == 3'd7) begin
                  w_bit_cnt_next = 3'd0;
                  if (r_byte_cnt == 4'd0) w_b0_next = w_byte_in;
                  if (r_byte_cnt == 4'd1) w_b1_next = w_byte_in;
                  if (r_byte_cnt == 4'd8) begin
                     w_state_next = ST_CHECK;
                  end else begin
                     w_byte_cnt_next = r_byte_cnt + 4'd1;
                  end
               end else begin
                  w_bit_cnt_next = r_bit_cnt + 3'd1;
               end
            end
         end
         ST_CHECK: begin
            // CRC over all nine bytes including the CRC byte leaves zero.
            if (w_crc == 8'h00) begin
               w_temp_next       = {r_b1, r_b0};
               w_temp_valid_next = 1'b1;
            end else begin
               w_err_next = ERR_CRC;
            end
            w_state_next = ST_FIN;
         end
         ST_FIN:  w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_ph         <= PH_ISSUE;
         r_guard      <= '0;
         r_bit_cnt    <= 3'd0;
         r_byte_cnt   <= 4'd0;
         r_poll_cnt   <= '0;
         r_shift      <= 8'h00;
         r_b0         <= 8'h00;
         r_b1         <= 8'h00;
         r_temp       <= 16'h0000;
         r_temp_valid <= 1'b0;
         r_err        <= ERR_OK;
      end else begin
         r_state      <= w_state_next;
         r_ph         <= w_ph_next;
         r_guard      <= w_guard_next;
         r_bit_cnt    <= w_bit_cnt_next;
         r_byte_cnt   <= w_byte_cnt_next;
         r_poll_cnt   <= w_poll_cnt_next;
         r_shift      <= w_shift_next;
         r_b0         <= w_b0_next;
         r_b1         <= w_b1_next;
         r_temp       <= w_temp_next;
         r_temp_valid <= w_temp_valid_next;
         r_err        <= w_err_next;
      end
   end

endmodule

// File: tb/tb_owr_temp_seq.sv
// Bench for owr_temp_seq: behavioural owm master (40-cycle slots) plus a
// DS18B20 model decoding the written commands; table rows plus corner sequences.
module tb_owr_temp_seq;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        busy;
   logic        done;
   logic [15:0] temp;
   logic        temp_valid;
   logic [1:0]  err;
   logic        bus_ren;
   logic        bus_wen;
   logic        bus_adr;
   logic [31:0] bus_wdt;
   logic [31:0] bus_rdt;

   always #5 clk = ~clk;

   owr_temp_seq #(.BWD(32), .POLL_MAX(4), .GUARD(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .busy       (busy),
      .done       (done),
      .temp       (temp),
      .temp_valid (temp_valid),
      .err        (err),
      .bus_ren    (bus_ren),
      .bus_wen    (bus_wen),
      .bus_adr    (bus_adr),
      .bus_wdt    (bus_wdt),
      .bus_rdt    (bus_rdt)
   );

   // ---------------- owm + sensor model ----------------
   int          m_busy = 0;
   logic        m_res = 1'b0;
   int          m_mode = 0;
   int          m_nbit = 0;
   logic [7:0]  m_cmd = 8'h00;
   int          m_polls = 0;
   int          m_idx = 0;
   logic [71:0] m_sp = '0;
   bit          m_present = 1'b1;
   int          m_conv_polls = 3;

   int n_wen = 0, n_rst_slots = 0, n_poll_slots = 0, n_rd_slots = 0, n_done = 0;
   logic [7:0] wdt_log[$];
   logic [7:0] exp_log[$];

   assign bus_rdt = {28'd0, (m_busy != 0), 2'b00, m_res};

   always @(negedge clk) begin
      if (m_busy > 0) m_busy = m_busy - 1;
      if (done) n_done = n_done + 1;
      if (bus_wen) begin
         n_wen = n_wen + 1;
         wdt_log.push_back(bus_wdt[7:0]);
         m_busy = 40;
         if (bus_wdt[7:0] == 8'h0A) begin
            n_rst_slots = n_rst_slots + 1;
            m_res  = !m_present;
            m_mode = 0;
            m_nbit = 0;
         end else begin
            case (m_mode)
               0, 1: begin
                  m_res  = bus_wdt[0];
                  m_cmd  = {bus_wdt[0], m_cmd[7:1]};
                  m_nbit = m_nbit + 1;
                  if (m_nbit == 8) begin
                     m_nbit = 0;
                     if (m_mode == 0) m_mode = 1;
                     else if (m_cmd == 8'h44) begin m_mode = 2; m_polls = 0; end
                     else if (m_cmd == 8'hBE) begin m_mode = 3; m_idx = 0; end
                     else m_mode = 4;
                  end
               end
               2: begin
                  n_poll_slots = n_poll_slots + 1;
                  m_polls = m_polls + 1;
                  m_res = (m_polls > m_conv_polls);
               end
               3: begin
                  n_rd_slots = n_rd_slots + 1;
                  m_res = (m_idx < 72) ? m_sp[m_idx] : 1'b1;
                  m_idx = m_idx + 1;
               end
               default: m_res = 1'b1;
            endcase
         end
      end
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_byte(input logic [7:0] b);
      for (int i = 0; i < 8; i++) exp_log.push_back(b[i] ? 8'h09 : 8'h08);
   endtask

   task automatic clear_counts();
      n_wen = 0; n_rst_slots = 0; n_poll_slots = 0; n_rd_slots = 0; n_done = 0;
      wdt_log.delete();
   endtask

   typedef struct {
      bit         present;
      int         conv_polls;
      logic [7:0] last;
      bit         extra_start;
      bit         fin_start;
      logic [1:0] exp_err;
      logic [15:0] exp_temp;
      bit         exp_valid;
      int         exp_wen;
      int         exp_rst;
      int         exp_poll;
      int         exp_rd;
   } vec_t;

   vec_t vecs[4];

   task automatic run_row(input int r, input vec_t v);
      int cyc;
      bit got;
      clear_counts();
      m_present    = v.present;
      m_conv_polls = v.conv_polls;
      m_sp         = {v.last, 64'h100C_FF7F_464B_0550};
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("busy_after_start", busy, 1);
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 20000) begin
         if (done) got = 1'b1;
         else begin
            @(negedge clk);
            cyc++;
            start = (v.extra_start && cyc == 300);
         end
      end
      chk("done_seen", got, 1);
      chk("err", err, v.exp_err);
      chk("temp", temp, v.exp_temp);
      chk("temp_valid", temp_valid, v.exp_valid);
      chk("busy_in_fin", busy, 0);
      if (v.fin_start) start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (100) @(negedge clk);
      chk("done_pulses", n_done, 1);
      chk("wen_pulses", n_wen, v.exp_wen);
      chk("reset_slots", n_rst_slots, v.exp_rst);
      chk("poll_slots", n_poll_slots, v.exp_poll);
      chk("read_slots", n_rd_slots, v.exp_rd);
      chk("idle_busy", busy, 0);
      $display("row %0d: err=%0d temp=0x%04h valid=%0d wen=%0d polls=%0d cycles=%0d",
               r, err, temp, temp_valid, n_wen, n_poll_slots, cyc);
   endtask

   initial begin
      int cyc;
      int first_bad;
      vecs[0] = '{1'b0, 3,    8'h1C, 1'b0, 1'b1, 2'd1, 16'h0000, 1'b0, 1,   1, 0, 0};
      vecs[1] = '{1'b1, 3,    8'h1C, 1'b0, 1'b0, 2'd0, 16'h0550, 1'b1, 110, 2, 4, 72};
      vecs[2] = '{1'b1, 3,    8'h1D, 1'b1, 1'b0, 2'd3, 16'h0550, 1'b1, 110, 2, 4, 72};
      vecs[3] = '{1'b1, 1000, 8'h1C, 1'b0, 1'b1, 2'd2, 16'h0550, 1'b1, 22,  1, 5, 0};

      exp_log.push_back(8'h0A);
      exp_byte(8'hCC);
      exp_byte(8'h44);
      for (int i = 0; i < 4; i++) exp_log.push_back(8'h09);
      exp_log.push_back(8'h0A);
      exp_byte(8'hCC);
      exp_byte(8'hBE);
      for (int i = 0; i < 72; i++) exp_log.push_back(8'h09);

      repeat (4) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_temp", temp, 0);
      chk("rst_valid", temp_valid, 0);
      chk("rst_err", err, 0);
      chk("rst_wen", bus_wen, 0);
      chk("rst_ren", bus_ren, 0);
      chk("rst_wdt", bus_wdt, 0);

      for (int r = 0; r < 4; r++) begin
         run_row(r, vecs[r]);
         if (r == 1) begin
            chk("wdt_len", wdt_log.size(), exp_log.size());
            first_bad = -1;
            for (int i = 0; i < wdt_log.size() && i < exp_log.size(); i++)
               if (first_bad < 0 && wdt_log[i] !== exp_log[i]) first_bad = i;
            chk("wdt_seq_first_bad_index", first_bad, 32'hFFFF_FFFF);
         end
      end

      // reset in the middle of the scratchpad read, with a stray start while busy
      clear_counts();
      m_present = 1'b1; m_conv_polls = 3;
      m_sp = {8'h1C, 64'h100C_FF7F_464B_0550};
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      cyc = 0;
      while (n_rd_slots < 20 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         start = (cyc == 200);
      end
      start = 1'b0;
      chk("reached_rdb", (n_rd_slots >= 20), 1);
      chk("rdb_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_temp", temp, 0);
      chk("abort_valid", temp_valid, 0);
      chk("abort_err", err, 0);
      chk("abort_wen", bus_wen, 0);
      chk("abort_ren", bus_ren, 0);
      chk("abort_wdt", bus_wdt, 0);
      cyc = n_wen;
      repeat (200) @(negedge clk);
      chk("abort_no_writes", n_wen, cyc);
      chk("abort_no_done", n_done, 0);
      $display("abort: rd_slots=%0d wen=%0d busy=%0d", n_rd_slots, n_wen, busy);

      run_row(4, vecs[1]);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
